serial_capture: RTL and testbench

SERIAL_CAPTURE -- requirements
Module: serial_capture

---
 rtl/serial_capture_pkg.sv | 19 +
 rtl/capture_ram.sv | 33 +++
 rtl/serial_capture.sv | 109 ++++++++++
 tb/tb_serial_capture.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_capture_pkg.sv
// Shared constants for the serial capture path.
// Both this block and the upstream pattern generator import this package.
// The generator emits EXPECT_EVEN at even word addresses and EXPECT_ODD at
// odd ones, so the two sides stay in step.
package serial_capture_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned ERR_W = 5;

    localparam logic [WIDTH-1:0] EXPECT_EVEN = 8'hCC;
    localparam logic [WIDTH-1:0] EXPECT_ODD  = 8'hAA;

    // Returns the reference word for a RAM address, given that address's LSB.
    function automatic logic [WIDTH-1:0] expected_word(input logic odd);
        return odd ? EXPECT_ODD : EXPECT_EVEN;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Capture RAM: one synchronous write port and one asynchronous read port.
// The contents have no reset.
// Ports:
//   clock   - write clock (rising edge)
//   we      - write enable
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - combinational read data. While a write to the same address is
//             pending, this shows the old contents until the clock edge.
module capture_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/serial_capture.sv
// Serial capture block.
// It deserialises din (bit 0 first) into words and stores each completed
// word in the capture RAM. It also checks every completed word against the
// reference pattern.
// Ports:
//   clock, reset - rising-edge clock; asynchronous active-low reset
//   din, en      - serial data bit and its sample enable
//   clr          - synchronous clear of counters and flags; has priority over en
//   rd_addr      - capture RAM read address
//   rd_data      - combinational read data from the capture RAM
//   word         - last completed word (registered)
//   word_addr    - RAM address at which that word was written
//   word_valid   - one-cycle pulse for each completed word
//   frame_done   - sticky flag, set when the word at address DEPTH-1 completes
//   err_cnt      - saturating count of words that do not match the pattern
module serial_capture
    import serial_capture_pkg::*;
#(
    parameter int unsigned WIDTH = serial_capture_pkg::WIDTH,
    parameter int unsigned DEPTH = serial_capture_pkg::DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     din,
    input  logic                     en,
    input  logic                     clr,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic [WIDTH-1:0]         word,
    output logic [$clog2(DEPTH)-1:0] word_addr,
    output logic                     word_valid,
    output logic                     frame_done,
    output logic [ERR_W-1:0]         err_cnt
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned BIT_W  = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    logic [BIT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  assembled;
    logic [WIDTH-1:0]  exp_word;
    logic              word_done;

    // The last bit completes the word on the same edge that samples it, so
    // the assembled word takes din directly in place of the MSB.
    always_comb begin
        assembled            = shreg;
        assembled[WIDTH-1]   = din;
    end

    assign exp_word  = WIDTH'(expected_word(wr_addr[0]));
    assign word_done = en && !clr && (bit_cnt == LAST_BIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            wr_addr    <= '0;
            shreg      <= '0;
            word       <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            bit_cnt    <= '0;
            wr_addr    <= '0;
            shreg      <= '0;
            word       <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            err_cnt    <= '0;
        end else begin
            word_valid <= 1'b0;
            if (en) begin
                shreg[bit_cnt] <= din;
                bit_cnt        <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    word       <= assembled;
                    word_addr  <= wr_addr;
                    word_valid <= 1'b1;
                    wr_addr    <= wr_addr + 1'b1;
                    if (assembled != exp_word && err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (wr_addr == '1) begin
                        frame_done <= 1'b1;
                    end
                end
            end
        end
    end

    capture_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clock  (clock),
        .we     (word_done),
        .wr_addr(wr_addr),
        .wr_data(assembled),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_serial_capture.sv
// Self-checking bench for serial_capture.
// The reference model buffers the received bits in a queue and counts words
// since the last clear. It rebuilds the expected outputs and RAM contents
// from those.
module tb_serial_capture;

    logic       clock;
    logic       reset;
    logic       din;
    logic       en;
    logic       clr;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] word;
    logic [3:0] word_addr;
    logic       word_valid;
    logic       frame_done;
    logic [4:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         bitq[$];
    int         widx;
    logic [7:0] m_word;
    int         m_addr;
    bit         m_valid;
    bit         m_frame;
    int         m_err;
    logic [7:0] m_ram [16];
    bit         m_known [16];

    serial_capture #(.WIDTH(8), .DEPTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .din       (din),
        .en        (en),
        .clr       (clr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .word      (word),
        .word_addr (word_addr),
        .word_valid(word_valid),
        .frame_done(frame_done),
        .err_cnt   (err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pattern(input int addr);
        return (addr % 2 == 1) ? 8'hAA : 8'hCC;
    endfunction

    task automatic model_clear();
        bitq.delete();
        widx    = 0;
        m_word  = 8'h00;
        m_addr  = 0;
        m_valid = 0;
        m_frame = 0;
        m_err   = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(word_valid), 32'(m_valid));
        chk({tag, ".word"},  32'(word),       32'(m_word));
        chk({tag, ".addr"},  32'(word_addr),  32'(m_addr));
        chk({tag, ".frame"}, 32'(frame_done), 32'(m_frame));
        chk({tag, ".err"},   32'(err_cnt),    32'(m_err));
    endtask

    // One clock cycle.
    // The read address points at the next word slot, so a word that
    // completes this cycle exercises read-during-write on the same address.
    task automatic cycle(input bit d, input bit e, input bit c);
        logic [7:0] w;
        int         a;
        din     = d;
        en      = e;
        clr     = c;
        rd_addr = 4'(widx % 16);
        #1;
        if (m_known[rd_addr]) chk("rd_pre", 32'(rd_data), 32'(m_ram[rd_addr]));
        @(posedge clock);
        if (c) begin
            model_clear();
        end else begin
            m_valid = 0;
            if (e) begin
                bitq.push_back(d);
                if (bitq.size() == 8) begin
                    for (int i = 0; i < 8; i++) w[i] = bitq[i];
                    a          = widx % 16;
                    m_ram[a]   = w;
                    m_known[a] = 1;
                    m_word     = w;
                    m_addr     = a;
                    m_valid    = 1;
                    if (w != pattern(a) && m_err < 31) m_err++;
                    if (a == 15) m_frame = 1;
                    widx++;
                    bitq.delete();
                end
            end
        end
        #1;
        check_outputs("cyc");
        if (m_known[rd_addr]) chk("rd_post", 32'(rd_data), 32'(m_ram[rd_addr]));
    endtask

    task automatic send_bits(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) cycle(w[i], 1'b1, 1'b0);
    endtask

    // Assert reset between clock edges, check that the outputs drop at once,
    // then release it away from the edge.
    task automatic async_reset();
        en  = 1'b0;
        clr = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_outputs("rst");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            if (m_known[i]) chk(tag, 32'(rd_data), 32'(m_ram[i]));
        end
    endtask

    initial begin
        reset   = 1'b0;
        din     = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        rd_addr = 4'd0;
        for (int i = 0; i < 16; i++) m_known[i] = 0;
        model_clear();
        #1;
        check_outputs("reset_state");
        @(negedge clock);
        reset = 1'b1;

        // S1: one clean frame of the expected pattern
        for (int k = 0; k < 16; k++) send_bits(pattern(k), 8);
        chk("s1.frame", 32'(frame_done), 32'd1);
        chk("s1.err",   32'(err_cnt),    32'd0);
        readback("s1.ram");

        // S2: bit 0 of word 3 flipped
        async_reset();
        for (int k = 0; k < 16; k++) send_bits((k == 3) ? (pattern(k) ^ 8'h01) : pattern(k), 8);
        chk("s2.err", 32'(err_cnt), 32'd1);
        rd_addr = 4'd3;
        #1;
        chk("s2.ram3", 32'(rd_data), 32'hAB);

        // S3: five-cycle en stall after bit 4 of word 2, then the frame completes
        async_reset();
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin
                send_bits(pattern(k), 5);
                for (int s = 0; s < 5; s++) cycle(1'($urandom), 1'b0, 1'b0);
                for (int i = 5; i < 8; i++) cycle(pattern(k) >> i, 1'b1, 1'b0);
                chk("s3.word2", 32'(word), 32'hCC);
            end else begin
                send_bits(pattern(k), 8);
            end
        end
        chk("s3.frame", 32'(frame_done), 32'd1);

        // S4: clr after bit 5 of word 6 while frame_done is still set
        for (int k = 0; k < 6; k++) send_bits(pattern(k), 8);
        send_bits(pattern(6), 6);
        cycle(1'b1, 1'b1, 1'b1);
        chk("s4.frame", 32'(frame_done), 32'd0);
        send_bits(8'hCC, 8);
        chk("s4.addr0", 32'(word_addr), 32'd0);
        chk("s4.valid", 32'(word_valid), 32'd1);

        // S5: reset in the middle of a word discards the partial bits
        send_bits(8'hAA, 3);
        async_reset();
        send_bits(8'hCC, 8);
        chk("s5.addr0", 32'(word_addr), 32'd0);
        chk("s5.word",  32'(word),      32'hCC);

        // S6: 40 zero words, so the error count saturates and the address wraps
        cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 40; k++) send_bits(8'h00, 8);
        chk("s6.err",   32'(err_cnt),    32'd31);
        chk("s6.frame", 32'(frame_done), 32'd1);
        chk("s6.addr",  32'(word_addr),  32'd7);

        // Random traffic: random data, mostly-enabled en, occasional clr
        cycle(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 2));
        end
        readback("rand.ram");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
